bin2bcd_scan: RTL

Parametrised binary-to-decimal display driver for the temperature readout path. It accepts a binary value with a half-unit flag and converts it to BCD with a multi-cycle shift-add-3 (double-dabble) engine behind a start/busy/done handshake. It holds the result in a display register and time-multiplexes it onto a DIGITS-position seven-segment decoder with blanking, overflow indication and a "Hi" message mode. It sits between the sensor/averaging logic and the existing 4-bit-code segment decoder.

---
 rtl/bin2bcd_pkg.sv | 26 ++
 rtl/bin2bcd_scan_dabble.sv | 89 ++++++++
 rtl/bin2bcd_scan.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared codes, converter state and BCD sizing helper
// Purpose: display code constants used by the scanner, the converter state
// enum, and bcd_digits() which sizes the internal BCD accumulator.
// Ports: none (package).

package bin2bcd_pkg;

  localparam logic [3:0] CODE_C     = 4'd10;
  localparam logic [3:0] CODE_H     = 4'd11;
  localparam logic [3:0] CODE_I     = 4'd12;
  localparam logic [3:0] CODE_BLANK = 4'd13;
  localparam logic [3:0] CODE_DASH  = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_t;

  // Decimal digit count of 2^width-1. 2^width is never a power of ten, so
  // this equals floor(width*log10(2))+1; log10(2) is held as 0.30103.
  function automatic int bcd_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_scan_dabble.sv
// rtl/bin2bcd_scan_dabble.sv - sequential shift-add-3 binary to BCD converter
// Purpose: converts data to BCD one bit per cycle behind a start/busy handshake.
// Ports:
//   clk, reset (sync, active-low)
//   start, data[DATA_W], half  - request, sampled when idle
//   busy                       - conversion in progress (SHIFT or LOAD)
//   valid                      - one cycle high in LOAD; bcd/bcd_half are final
//   bcd[4*NBCD], bcd_half      - converted value and latched half flag

module bcd_dabble_seq
  import bin2bcd_pkg::*;
#(
  parameter int DATA_W = 8,
  localparam int NBCD = bcd_digits(DATA_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   data,
  input  logic                half,
  output logic                busy,
  output logic                valid,
  output logic [4*NBCD-1:0]   bcd,
  output logic                bcd_half
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  conv_state_t        state, state_next;
  logic [DATA_W-1:0]  bin_q;
  logic [4*NBCD-1:0]  bcd_q;
  logic [4*NBCD-1:0]  bcd_adj;
  logic               half_q;
  logic [CNT_W-1:0]   cnt_q;

  // Add-3 correction on every nibble that would exceed 9 after doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt_q == LAST_CNT) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      bin_q  <= '0;
      bcd_q  <= '0;
      half_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            bin_q  <= data;
            half_q <= half;
            bcd_q  <= '0;
            cnt_q  <= '0;
          end
        end
        SHIFT: begin
          bcd_q <= {bcd_adj[4*NBCD-2:0], bin_q[DATA_W-1]};
          bin_q <= {bin_q[DATA_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign valid    = (state == LOAD);
  assign bcd      = bcd_q;
  assign bcd_half = half_q;

endmodule

// File: rtl/bin2bcd_scan.sv
// rtl/bin2bcd_scan.sv - BCD display register, blanking/overflow/message mux and digit scanner
// Purpose: converts a binary reading (plus .5 flag) and time-multiplexes it
// onto a DIGITS-position segment decoder: pos0 unit 'C', pos1 fraction,
// pos2.. integer digits ones upward.
// Ports:
//   clk, reset (sync, active-low)
//   start, data[DATA_W], half  - conversion request, accepted when busy=0
//   msg_mode                   - live select of the "Hi" message
//   busy, done                 - conversion in progress / display register loaded
//   digit_sel, digit_code[4]   - registered scan position and its code

module bin2bcd_scan
  import bin2bcd_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DATA_W-1:0]          data,
  input  logic                       half,
  input  logic                       msg_mode,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DIGITS)-1:0]  digit_sel,
  output logic [3:0]                 digit_code
);

  localparam int NBCD  = bcd_digits(DATA_W);
  localparam int NPAD  = (NBCD > DIGITS) ? NBCD : DIGITS;
  localparam int SEL_W = $clog2(DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic               conv_busy;
  logic               conv_valid;
  logic [4*NBCD-1:0]  conv_bcd;
  logic               conv_half;
  logic               conv_ovf;

  logic [4*NBCD-1:0]  disp_bcd_q;
  logic               disp_half_q;
  logic               disp_ovf_q;
  logic               done_q;

  logic [PRE_W-1:0]   presc_q, presc_next;
  logic [SEL_W-1:0]   sel_q, sel_next;
  logic [3:0]         code_q, code_next;
  logic               wrap;

  logic [4*NPAD-1:0]  pad;
  logic [3:0]         pos_code [DIGITS];
  logic [3:0]         dig;
  logic               seen;

  bcd_dabble_seq #(.DATA_W(DATA_W)) u_dabble (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data     (data),
    .half     (half),
    .busy     (conv_busy),
    .valid    (conv_valid),
    .bcd      (conv_bcd),
    .bcd_half (conv_half)
  );

  // Any digit that has no display position means the value cannot be shown.
  always_comb begin
    conv_ovf = 1'b0;
    for (int i = 0; i < NBCD; i++) begin
      if (i >= DIGITS - 2)
        conv_ovf = conv_ovf | (conv_bcd[4*i +: 4] != 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      disp_bcd_q  <= '0;
      disp_half_q <= 1'b0;
      disp_ovf_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= conv_valid;
      if (conv_valid) begin
        disp_bcd_q  <= conv_bcd;
        disp_half_q <= conv_half;
        disp_ovf_q  <= conv_ovf;
      end
    end
  end

  // Code for every position from the current display register and msg_mode.
  // Integer digits are walked from the top down so leading zeros blank
  // until the first nonzero digit; the ones digit is never blanked.
  always_comb begin
    pad = '0;
    pad[4*NBCD-1:0] = disp_bcd_q;
    seen = 1'b0;
    dig  = 4'd0;
    for (int k = 0; k < DIGITS; k++) pos_code[k] = CODE_BLANK;
    for (int k = DIGITS - 1; k >= 2; k--) begin
      dig  = pad[4*(k-2) +: 4];
      seen = seen | (dig != 4'd0);
      pos_code[k] = ((k > 2) && !seen) ? CODE_BLANK : dig;
    end
    pos_code[1] = disp_half_q ? 4'd5 : 4'd0;
    pos_code[0] = CODE_C;
    if (disp_ovf_q) begin
      for (int k = 1; k < DIGITS; k++) pos_code[k] = CODE_DASH;
    end
    if (msg_mode) begin
      for (int k = 0; k < DIGITS; k++) pos_code[k] = CODE_BLANK;
      pos_code[1] = CODE_I;
      pos_code[2] = CODE_H;
    end
  end

  always_comb begin
    wrap       = (presc_q == PRE_LAST);
    presc_next = wrap ? '0 : presc_q + 1'b1;
    sel_next   = sel_q;
    if (wrap) sel_next = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
  end

  // The code register is loaded from the position that digit_sel moves to,
  // so the registered pair is always consistent.
  always_comb begin
    code_next = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (sel_next == SEL_W'(k)) code_next = pos_code[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      sel_q   <= '0;
      code_q  <= 4'd0;
    end else begin
      presc_q <= presc_next;
      sel_q   <= sel_next;
      code_q  <= code_next;
    end
  end

  assign busy       = conv_busy;
  assign done       = done_q;
  assign digit_sel  = sel_q;
  assign digit_code = code_q;

endmodule
